// File: rtl/quadrilatero_pkg.sv
// Shared types, defaults and helpers for the matrix register file write-port responder.
package quadrilatero_pkg;

  localparam int unsigned RLenDefault    = 128;
  localparam int unsigned NRegsDefault   = 8;
  localparam int unsigned NRowsDefault   = 4;
  localparam int unsigned NWportsDefault = 2;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [$clog2(NRegsDefault)-1:0] reg_idx_t;
  typedef logic [$clog2(NRowsDefault)-1:0] row_idx_t;
  typedef logic [RLenDefault-1:0]          row_data_t;

endpackage

// File: rtl/quadrilatero_rf_wport_responder_if.sv
// Row-write bundle between write initiators (master) and the register file (slave).
interface quadrilatero_rf_wport_responder_if
  import quadrilatero_pkg::*;
#(
  parameter int unsigned RLEN     = RLenDefault,
  parameter int unsigned N_REGS   = NRegsDefault,
  parameter int unsigned N_ROWS   = NRowsDefault,
  parameter int unsigned N_WPORTS = NWportsDefault
);
  localparam int unsigned RegW = idx_w(N_REGS);
  localparam int unsigned RowW = idx_w(N_ROWS);

  logic [N_WPORTS-1:0][RegW-1:0] waddr;
  logic [N_WPORTS-1:0][RowW-1:0] wrowaddr;
  logic [N_WPORTS-1:0][RLEN-1:0] wdata;
  logic [N_WPORTS-1:0]           we;
  logic [N_WPORTS-1:0]           wlast;
  logic [N_WPORTS-1:0]           wready;

  modport master (output waddr, output wrowaddr, output wdata, output we, output wlast,
                  input wready);
  modport slave  (input waddr, input wrowaddr, input wdata, input we, input wlast,
                  output wready);
endinterface

// File: rtl/quadrilatero_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer, wrapping.
module quadrilatero_rr_arbiter
  import quadrilatero_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned PtrW = idx_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    // Upper segment [ptr, N) first, then the wrapped segment [0, ptr).
    for (int j = 0; j < int'(N); j++) begin
      if (!found && req_i[j] && (j >= int'(ptr_i))) begin
        gnt_o[j] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int j = 0; j < int'(N); j++) begin
      if (!found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/quadrilatero_rf_wport_responder.sv
// Matrix register storage with arbitrated, burst-locked row writes and one async read port.
module quadrilatero_rf_wport_responder
  import quadrilatero_pkg::*;
#(
  parameter int unsigned RLEN     = RLenDefault,
  parameter int unsigned N_REGS   = NRegsDefault,
  parameter int unsigned N_ROWS   = NRowsDefault,
  parameter int unsigned N_WPORTS = NWportsDefault,
  localparam int unsigned RegW  = idx_w(N_REGS),
  localparam int unsigned RowW  = idx_w(N_ROWS),
  localparam int unsigned PortW = idx_w(N_WPORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  quadrilatero_rf_wport_responder_if.slave wport,
  input  logic [RegW-1:0]      raddr_i,
  input  logic [RowW-1:0]      rrowaddr_i,
  output logic [RLEN-1:0]      rdata_o,
  output logic [N_REGS-1:0]    reg_wip_o,
  output logic                 wdone_o,
  output logic [RegW-1:0]      wdone_reg_o,
  output logic [PortW-1:0]     wdone_port_o,
  output logic                 err_o,
  input  logic                 clear_err_i
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  localparam logic [RowW-1:0] LastRow  = RowW'(N_ROWS - 1);
  localparam bit              RegsPow2 = ((32'd1 << RegW) == N_REGS);
  localparam bit              RowsPow2 = ((32'd1 << RowW) == N_ROWS);

  if (N_ROWS < 2) begin : g_rows_chk
    $error("N_ROWS must be at least 2");
  end
  if (N_WPORTS < 1) begin : g_ports_chk
    $error("N_WPORTS must be at least 1");
  end

  logic [0:0]       state_q, state_d;
  logic [PortW-1:0] lock_port_q, lock_port_d;
  logic [RegW-1:0]  lock_reg_q, lock_reg_d;
  logic [RowW-1:0]  row_cnt_q, row_cnt_d;
  logic [PortW-1:0] rr_ptr_q, rr_ptr_d;
  logic             wdone_q, wdone_d;
  logic [RegW-1:0]  wdone_reg_q, wdone_reg_d;
  logic [PortW-1:0] wdone_port_q, wdone_port_d;
  logic             err_q, err_d;

  logic [N_REGS-1:0][N_ROWS-1:0][RLEN-1:0] mem_q;

  logic [N_WPORTS-1:0] gnt, wready;
  logic [PortW-1:0]    gnt_idx, sel_port;
  logic [RegW-1:0]     beat_reg;
  logic [RowW-1:0]     beat_row;
  logic [RLEN-1:0]     beat_data;
  logic                beat_last, beat_acc, beat_err, reg_oob, row_oob;

  quadrilatero_rr_arbiter #(
    .N (N_WPORTS)
  ) u_arb (
    .req_i (wport.we),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  // wready is a function of we and lock state only, so wlast may depend on it.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < int'(N_WPORTS); i++) begin
      if (gnt[i]) gnt_idx = PortW'(i);
    end
    wready = '0;
    if (state_q == StLocked) begin
      wready[lock_port_q] = 1'b1;
      sel_port            = lock_port_q;
      beat_reg            = lock_reg_q;
    end else begin
      wready   = gnt;
      sel_port = gnt_idx;
      beat_reg = wport.waddr[gnt_idx];
    end
    beat_row  = wport.wrowaddr[sel_port];
    beat_data = wport.wdata[sel_port];
    beat_last = wport.wlast[sel_port];
    beat_acc  = wport.we[sel_port] & wready[sel_port];
    reg_oob   = !RegsPow2 && (32'(beat_reg) >= N_REGS);
    row_oob   = !RowsPow2 && (32'(beat_row) >= N_ROWS);
    beat_err  = beat_acc && ((beat_row != row_cnt_q) ||
                             (beat_last != (row_cnt_q == LastRow)) || reg_oob);
  end

  assign wport.wready = wready;

  always_comb begin
    state_d      = state_q;
    lock_port_d  = lock_port_q;
    lock_reg_d   = lock_reg_q;
    row_cnt_d    = row_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    wdone_d      = 1'b0;
    wdone_reg_d  = wdone_reg_q;
    wdone_port_d = wdone_port_q;
    err_d        = beat_err ? 1'b1 : (clear_err_i ? 1'b0 : err_q);
    if (beat_acc) begin
      if (beat_last) begin
        state_d      = StIdle;
        row_cnt_d    = '0;
        wdone_d      = 1'b1;
        wdone_reg_d  = beat_reg;
        wdone_port_d = sel_port;
      end else if (state_q == StIdle) begin
        state_d     = StLocked;
        lock_port_d = sel_port;
        lock_reg_d  = beat_reg;
        row_cnt_d   = RowW'(1);
        rr_ptr_d    = (32'(sel_port) == N_WPORTS - 1) ? '0 : sel_port + 1'b1;
      end else begin
        row_cnt_d = (row_cnt_q == LastRow) ? '0 : row_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      lock_port_q  <= '0;
      lock_reg_q   <= '0;
      row_cnt_q    <= '0;
      rr_ptr_q     <= '0;
      wdone_q      <= 1'b0;
      wdone_reg_q  <= '0;
      wdone_port_q <= '0;
      err_q        <= 1'b0;
      mem_q        <= '0;
    end else begin
      state_q      <= state_d;
      lock_port_q  <= lock_port_d;
      lock_reg_q   <= lock_reg_d;
      row_cnt_q    <= row_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      wdone_q      <= wdone_d;
      wdone_reg_q  <= wdone_reg_d;
      wdone_port_q <= wdone_port_d;
      err_q        <= err_d;
      if (beat_acc && !reg_oob && !row_oob) mem_q[beat_reg][beat_row] <= beat_data;
    end
  end

  always_comb begin
    reg_wip_o = '0;
    if (state_q == StLocked && (32'(lock_reg_q) < N_REGS)) reg_wip_o[lock_reg_q] = 1'b1;
    rdata_o = '0;
    if ((32'(raddr_i) < N_REGS) && (32'(rrowaddr_i) < N_ROWS)) begin
      rdata_o = mem_q[raddr_i][rrowaddr_i];
    end
  end

  assign wdone_o      = wdone_q;
  assign wdone_reg_o  = wdone_reg_q;
  assign wdone_port_o = wdone_port_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_quadrilatero_rf_wport_responder.sv
// Scoreboard bench: completions queued on last beats, reads checked against a shadow memory.
module tb_quadrilatero_rf_wport_responder;
  import quadrilatero_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   raddr;
  logic [1:0]   rrowaddr;
  logic [127:0] rdata;
  logic [7:0]   reg_wip;
  logic         wdone;
  logic [2:0]   wdone_reg;
  logic [0:0]   wdone_port;
  logic         err;
  logic         clear_err;

  logic [1:0]   wlast_drv;
  bit           zmode;
  int           zcnt;

  typedef struct packed {
    logic [2:0] r;
    logic [0:0] p;
  } done_t;

  done_t        sb_q[$];
  done_t        sb_e;
  logic [127:0] ref_mem [8][4];
  int           n_total = 0;
  int           n_bad   = 0;

  always #5 clk = ~clk;

  quadrilatero_rf_wport_responder_if #(
    .RLEN     (128),
    .N_REGS   (8),
    .N_ROWS   (4),
    .N_WPORTS (2)
  ) wif ();

  // Port 0 can emulate a producer whose wlast is gated by wready in the same cycle.
  assign wif.wlast[1] = wlast_drv[1];
  assign wif.wlast[0] = zmode ? ((zcnt == 3) && wif.wready[0]) : wlast_drv[0];

  quadrilatero_rf_wport_responder #(
    .RLEN     (128),
    .N_REGS   (8),
    .N_ROWS   (4),
    .N_WPORTS (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wport        (wif),
    .raddr_i      (raddr),
    .rrowaddr_i   (rrowaddr),
    .rdata_o      (rdata),
    .reg_wip_o    (reg_wip),
    .wdone_o      (wdone),
    .wdone_reg_o  (wdone_reg),
    .wdone_port_o (wdone_port),
    .err_o        (err),
    .clear_err_i  (clear_err)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    wif.we    = '0;
    wlast_drv = '0;
  endtask

  task automatic drive(input int p, input int r, input int row, input logic [127:0] d);
    wif.we[p]       = 1'b1;
    wif.waddr[p]    = 3'(r);
    wif.wrowaddr[p] = 2'(row);
    wif.wdata[p]    = d;
    wlast_drv[p]    = (row == 3);
  endtask

  task automatic note_beat(input int p, input int r, input int row, input logic [127:0] d,
                           input bit last);
    done_t e;
    ref_mem[r][row] = d;
    if (last) begin
      e.r = 3'(r);
      e.p = 1'(p);
      sb_q.push_back(e);
    end
  endtask

  task automatic check_read(input string tag, input int r, input int row);
    raddr    = 3'(r);
    rrowaddr = 2'(row);
    #1;
    check_val(tag, rdata, ref_mem[r][row]);
    tick();
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    idle_ports();
    clear_err = 1'b0;
    zmode     = 1'b0;
    zcnt      = 0;
    for (int i = 0; i < 8; i++) for (int j = 0; j < 4; j++) ref_mem[i][j] = '0;
    raddr    = 3'd2;
    rrowaddr = 2'd0;
    #1;
    check_val("rst_wready", wif.wready, 2'b00);
    check_val("rst_wdone", wdone, 1'b0);
    check_val("rst_wdone_reg", wdone_reg, 3'd0);
    check_val("rst_wdone_port", wdone_port, 1'b0);
    check_val("rst_err", err, 1'b0);
    check_val("rst_wip", reg_wip, 8'h00);
    check_val("rst_rdata", rdata, 128'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && wdone === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("wdone_unexpected", 1'b1, 1'b0);
      end else begin
        sb_e = sb_q.pop_front();
        check_val("wdone_reg", wdone_reg, sb_e.r);
        check_val("wdone_port", wdone_port, sb_e.p);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx0, idx1, exp_p, zbeats;
    bit  zacc;
    int  rows4 [4];

    wif.waddr    = '0;
    wif.wrowaddr = '0;
    wif.wdata    = '0;
    apply_reset();

    // Single initiator, reg 3.
    for (int r = 0; r < 4; r++) begin
      drive(0, 3, r, 128'hA0 + r);
      #1;
      check_val($sformatf("t1_wready_r%0d", r), wif.wready, 2'b01);
      if (r > 0) check_val($sformatf("t1_wip_r%0d", r), reg_wip, 8'h08);
      note_beat(0, 3, r, 128'hA0 + r, r == 3);
      tick();
    end
    idle_ports();
    check_val("t1_wdone", wdone, 1'b1);
    check_val("t1_wip_clear", reg_wip, 8'h00);
    tick();
    check_val("t1_wdone_pulse", wdone, 1'b0);
    for (int r = 0; r < 4; r++) check_read($sformatf("t1_rd_r%0d", r), 3, r);

    // Contention from reset; port 0 rerequests immediately and loses to the rr pointer.
    apply_reset();
    idx0 = 0;
    idx1 = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      idle_ports();
      if (idx0 < 8) drive(0, (idx0 < 4) ? 1 : 4, idx0 % 4, 128'hB0 + idx0);
      if (idx1 < 4) drive(1, 2, idx1, 128'hC0 + idx1);
      #1;
      exp_p = (cyc >= 4 && cyc < 8) ? 1 : 0;
      check_val($sformatf("t2_wready_c%0d", cyc), wif.wready, exp_p ? 2'b10 : 2'b01);
      if (exp_p == 0) begin
        note_beat(0, (idx0 < 4) ? 1 : 4, idx0 % 4, 128'hB0 + idx0, (idx0 % 4) == 3);
        idx0++;
      end else begin
        note_beat(1, 2, idx1, 128'hC0 + idx1, idx1 == 3);
        idx1++;
      end
      tick();
    end
    idle_ports();
    tick();
    check_read("t2_rd_r1_0", 1, 0);
    check_read("t2_rd_r2_2", 2, 2);
    check_read("t2_rd_r4_3", 4, 3);
    check_val("t2_err", err, 1'b0);

    // Port 0 with wready-gated wlast, waiting behind port 1.
    zmode  = 1'b1;
    zcnt   = 0;
    zbeats = 0;
    idx1   = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      idle_ports();
      if (idx1 < 4) drive(1, 7, idx1, 128'hD0 + idx1);
      if (zcnt < 4) begin
        wif.we[0]       = 1'b1;
        wif.waddr[0]    = 3'd6;
        wif.wrowaddr[0] = 2'(zcnt);
        wif.wdata[0]    = 128'hE0 + zcnt;
      end
      #1;
      exp_p = (cyc < 4) ? 1 : 0;
      check_val($sformatf("t3_wready_c%0d", cyc), wif.wready, exp_p ? 2'b10 : 2'b01);
      check_val($sformatf("t3_wlast_c%0d", cyc), wif.wlast[0], cyc == 7);
      zacc = wif.we[0] && wif.wready[0];
      if (zacc) zbeats++;
      if (exp_p == 1) begin
        note_beat(1, 7, idx1, 128'hD0 + idx1, idx1 == 3);
        idx1++;
      end else begin
        note_beat(0, 6, zcnt, 128'hE0 + zcnt, zcnt == 3);
      end
      tick();
      if (zacc) zcnt++;
    end
    idle_ports();
    tick();
    zmode = 1'b0;
    check_val("t3_beats", zbeats, 4);
    check_val("t3_err", err, 1'b0);
    check_read("t3_rd_r6_3", 6, 3);
    check_read("t3_rd_r7_1", 7, 1);

    // Out-of-order rows 0,2,1,3 on reg 0.
    rows4 = '{0, 2, 1, 3};
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, rows4[i], 128'hF0 + i);
      wlast_drv[0] = (i == 3);
      #1;
      if (i == 1) check_val("t4_err_before", err, 1'b0);
      if (i == 2) check_val("t4_err_after", err, 1'b1);
      note_beat(0, 0, rows4[i], 128'hF0 + i, i == 3);
      tick();
    end
    idle_ports();
    check_val("t4_wdone", wdone, 1'b1);
    tick();
    check_val("t4_err_sticky", err, 1'b1);
    check_read("t4_rd_r0_2", 0, 2);
    check_read("t4_rd_r0_1", 0, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check_val("t4_err_cleared", err, 1'b0);

    // Read-during-write on reg 5 row 1.
    drive(0, 5, 0, 128'h50);
    note_beat(0, 5, 0, 128'h50, 1'b0);
    tick();
    drive(0, 5, 1, 128'hFF);
    raddr    = 3'd5;
    rrowaddr = 2'd1;
    #1;
    check_val("t5_rd_old", rdata, 128'h0);
    note_beat(0, 5, 1, 128'hFF, 1'b0);
    tick();
    drive(0, 5, 2, 128'h52);
    #1;
    check_val("t5_rd_new", rdata, 128'hFF);
    note_beat(0, 5, 2, 128'h52, 1'b0);
    tick();
    drive(0, 5, 3, 128'h53);
    note_beat(0, 5, 3, 128'h53, 1'b1);
    tick();
    idle_ports();
    tick();

    // Reset in the middle of a burst, then a fresh burst from port 1.
    drive(0, 2, 0, 128'h60);
    tick();
    drive(0, 2, 1, 128'h61);
    tick();
    check_val("t6_wip_locked", reg_wip, 8'h04);
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      drive(1, 3, r, 128'h70 + r);
      #1;
      check_val($sformatf("t6_wready_r%0d", r), wif.wready, 2'b10);
      note_beat(1, 3, r, 128'h70 + r, r == 3);
      tick();
    end
    idle_ports();
    tick();
    check_read("t6_rd_r3_0", 3, 0);
    check_read("t6_rd_r3_3", 3, 3);
    check_read("t6_rd_r2_1", 2, 1);
    check_val("t6_err", err, 1'b0);

    check_val("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
